// File: rtl/multiplier_seq_pkg.sv
// rtl/multiplier_seq_pkg.sv - shared arithmetic package: state encoding, default width, clog2 helper
package multiplier_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Same encoding as the sequential divider so the two FSMs read alike on board.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - sequential shift-and-add multiply-accumulate, y = a*b + c in WIDTH cycles
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y
);

  localparam int              CW       = clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    a_q;
  logic [2*WIDTH:0]    acc_q;
  logic [2*WIDTH:0]    acc_step;
  logic [WIDTH:0]      upper_sum;
  logic                accept;
  logic                last_step;

  // One multiplier bit per step: the addend c seeds the upper half, b sits in the lower half
  // and is consumed from the LSB as the product shifts in from above.
  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH];
    if (acc_q[0]) upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, a_q};
    acc_step = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_ONE) begin
          last_step = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      acc_q <= '0;
      y     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        acc_q <= {1'b0, c, b};
        cnt_q <= CNT_LOAD;
      end else if (busy) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CNT_ONE;
        if (last_step) begin
          y    <= acc_step[2*WIDTH-1:0];
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - self-checking bench for multiplier_seq
module tb_multiplier_seq;

  localparam int W = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    c;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  y;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] y;
  } vec_t;

  vec_t vecs[7];

  multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Waits for a done pulse from the current point; n counts ticks taken, busy_cycles counts
  // busy-high samples seen before the done cycle.
  task automatic wait_done(input int limit, output int n, output int busy_cycles, output bit seen);
    n = 0;
    busy_cycles = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      if (busy) busy_cycles++;
      tick();
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic score(input string name);
    logic [2*W-1:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got done with y=%0d required no done (nothing outstanding)", name, y);
    end else begin
      exp = sb.pop_front();
      checks--;
      check(name, 64'(y), 64'(exp));
    end
  endtask

  task automatic expect_done(input string name, input int limit, input int exp_n, input int exp_busy);
    int  n;
    int  bc;
    bit  seen;
    wait_done(limit, n, bc, seen);
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles required done", name, n);
    end else begin
      score({name, "_y"});
      check({name, "_latency"}, 64'(n), 64'(exp_n));
      check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
      check({name, "_busy_at_done"}, 64'(busy), 64'(0));
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vc, input logic [2*W-1:0] exp);
    a = va;
    b = vb;
    c = vc;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    expect_done(name, 40, W, W);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;

    vecs[0] = '{a: 16'd32200, b: 16'd37,    c: 16'd0,      y: 32'd1191400};
    vecs[1] = '{a: 16'd870,   b: 16'd37,    c: 16'd10,     y: 32'd32200};
    vecs[2] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'hFFFF,   y: 32'hFFFF0000};
    vecs[3] = '{a: 16'd0,     b: 16'd12345, c: 16'd7,      y: 32'd7};
    vecs[4] = '{a: 16'd1,     b: 16'd1,     c: 16'd0,      y: 32'd1};
    vecs[5] = '{a: 16'hFFFF,  b: 16'd1,     c: 16'd0,      y: 32'h0000FFFF};
    vecs[6] = '{a: 16'h8000,  b: 16'h8000,  c: 16'h0001,   y: 32'h40000001};

    rst = 1'b1;
    start = 1'b1;
    a = 16'd5;
    b = 16'd5;
    c = 16'd5;

    // Reset held with start asserted: nothing may start.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_y", 64'(y), 64'(0));
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("post_reset_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].y);
    end

    // Start during busy is ignored: operands change and start pulses mid-run.
    a = 16'd3;
    b = 16'd5;
    c = 16'd1;
    start = 1'b1;
    sb.push_back(32'd16);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a = 16'd9;
    b = 16'd9;
    c = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_done("busy_start", 40, W - 5, W - 5);
    count_done(25, pulses);
    check("busy_start_no_extra_done", 64'(pulses), 64'(0));
    check("busy_start_y_held", 64'(y), 64'(16));

    // Back-to-back: start held high, next accept lands in each done cycle.
    a = 16'd2;
    b = 16'd3;
    c = 16'd0;
    start = 1'b1;
    sb.push_back(32'd6);
    tick();
    expect_done("b2b0", 40, W, W);
    for (int k = 1; k < 3; k++) begin
      sb.push_back(32'd6);
      if (k == 2) begin
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      check($sformatf("b2b%0d_busy_after_accept", k), 64'(busy), 64'(1));
      expect_done($sformatf("b2b%0d", k), 40, W, W);
    end
    count_done(25, pulses);
    check("b2b_no_extra_done", 64'(pulses), 64'(0));

    // Reset mid-operation aborts with no done pulse and clears y.
    a = 16'd100;
    b = 16'd100;
    c = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_y", 64'(y), 64'(0));
    rst = 1'b0;
    count_done(25, pulses);
    check("abort_no_done", 64'(pulses), 64'(0));
    run_op("after_abort", 16'd100, 16'd100, 16'd0, 32'd10000);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
